// File: rtl/parity_arbiter.sv
// rtl/parity_arbiter.sv - round-robin arbiter sharing one parity counter among NREQ requesters
// Optional watchdog on the WAIT state is enabled by defining PAR_WATCHDOG_EN.
module parity_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic               par_out,
    output logic               err,
    output logic               cnt_init,
    output logic [DW-1:0]      cnt_data,
    input  logic               cnt_done,
    input  logic               cnt_par
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic            par_r;
    logic            wd_expire;

    // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
    always_comb begin
        int            j;
        logic [IW-1:0] j_idx;
        sel_found = 1'b0;
        sel_idx   = rr_ptr;
        j         = 0;
        j_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            j_idx = IW'(j);
            if (!sel_found && req[j_idx]) begin
                sel_found = 1'b1;
                sel_idx   = j_idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel_found) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (cnt_done || wd_expire) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            cnt_data <= '0;
            par_r    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant    <= sel_idx;
                        cnt_data <= req_data[int'(sel_idx)*DW +: DW];
                    end
                end
                WAIT: begin
                    if (cnt_done)       par_r <= cnt_par;
                    else if (wd_expire) par_r <= 1'b0;
                end
                RESP: rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

    assign cnt_init = (state == START);
    assign ack      = (state == RESP) ? (NREQ'(1) << grant) : '0;
    assign par_out  = (state == RESP) && par_r;

`ifdef PAR_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt;
    logic           err_r;

    // wd_cnt counts completed WAIT cycles; expiry fires on the TIMEOUT-th one.
    assign wd_expire = (state == WAIT) && !cnt_done && (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            if (state == START) wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (state == WAIT) begin
                if (cnt_done)       err_r <= 1'b0;
                else if (wd_expire) err_r <= 1'b1;
            end
        end
    end

    assign err = (state == RESP) && err_r;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wd_expire      = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// tb/tb_parity_arbiter.sv - directed self-checking bench for parity_arbiter
module tb_parity_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    ack;
    logic               par_out;
    logic               err;
    logic               cnt_init;
    logic [DW-1:0]      cnt_data;
    logic               cnt_done = 1'b0;
    logic               cnt_par = 1'b0;

    int total  = 0;
    int passed = 0;

    parity_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .par_out(par_out), .err(err),
        .cnt_init(cnt_init), .cnt_data(cnt_data),
        .cnt_done(cnt_done), .cnt_par(cnt_par)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cnt_done = 1'b0;
        cnt_par = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Plays the counter for one transaction and reports what the DUT showed.
    task automatic serve(input logic par, output bit got, output logic [7:0] d_start,
                         output logic [7:0] d_resp, output logic [3:0] a,
                         output logic p, output logic e);
        got = 1'b0;
        d_resp = '0; a = '0; p = 1'b0; e = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (cnt_init) got = 1'b1;
        end
        d_start = cnt_data;
        if (!got) return;
        @(posedge clk); #1;
        cnt_done = 1'b1;
        cnt_par  = par;
        @(posedge clk); #1;
        a = ack; p = par_out; e = err; d_resp = cnt_data;
        cnt_done = 1'b0;
        cnt_par  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", ack); else passed++;
        if (cnt_init !== 1'b0) $display("FAIL reset_init got=%b exp=0", cnt_init); else passed++;
        if (par_out !== 1'b0) $display("FAIL reset_par got=%b exp=0", par_out); else passed++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passed++;
        if (cnt_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", cnt_data); else passed++;
    endtask

    task automatic test_single();
        bit got; logic [7:0] d0, d1; logic [3:0] a; logic p, e;
        do_reset();
        req_data[7:0] = 8'h4F;
        req = 4'b0001;
        serve(1'b1, got, d0, d1, a, p, e);
        total += 6;
        if (got !== 1'b1) $display("FAIL single_init got=%b exp=1", got); else passed++;
        if (d0 !== 8'h4F) $display("FAIL single_data got=%h exp=4f", d0); else passed++;
        if (d1 !== 8'h4F) $display("FAIL single_data_hold got=%h exp=4f", d1); else passed++;
        if (a !== 4'b0001) $display("FAIL single_ack got=%b exp=0001", a); else passed++;
        if (p !== 1'b1) $display("FAIL single_par got=%b exp=1", p); else passed++;
        if (e !== 1'b0) $display("FAIL single_err got=%b exp=0", e); else passed++;
        req = '0;
        @(posedge clk); #1;
        total++;
        if (ack !== 4'b0000) $display("FAIL single_ack_pulse got=%b exp=0000", ack); else passed++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d[4] = '{8'h00, 8'h01, 8'h03, 8'h07};
        logic       exp_p[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_a[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bit got; logic [7:0] d0, d1; logic [3:0] a; logic p, e;
        do_reset();
        req_data = {8'h07, 8'h03, 8'h01, 8'h00};
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            serve(exp_p[i], got, d0, d1, a, p, e);
            req = req & ~exp_a[i];
            total += 3;
            if (d0 !== exp_d[i]) $display("FAIL rr_data[%0d] got=%h exp=%h", i, d0, exp_d[i]); else passed++;
            if (a !== exp_a[i]) $display("FAIL rr_ack[%0d] got=%b exp=%b", i, a, exp_a[i]); else passed++;
            if (p !== exp_p[i]) $display("FAIL rr_par[%0d] got=%b exp=%b", i, p, exp_p[i]); else passed++;
        end
    endtask

    task automatic test_wrap();
        bit got; logic [7:0] d0, d1; logic [3:0] a; logic p, e;
        do_reset();
        req_data = {8'h00, 8'h22, 8'h00, 8'h11};
        req = 4'b0100;
        serve(1'b0, got, d0, d1, a, p, e);
        req = 4'b0101;
        serve(1'b0, got, d0, d1, a, p, e);
        req = 4'b0100;
        total += 2;
        if (a !== 4'b0001) $display("FAIL wrap_ack got=%b exp=0001", a); else passed++;
        if (d0 !== 8'h11) $display("FAIL wrap_data got=%h exp=11", d0); else passed++;
        serve(1'b0, got, d0, d1, a, p, e);
        req = '0;
        total++;
        if (a !== 4'b0100) $display("FAIL wrap_second_ack got=%b exp=0100", a); else passed++;
    endtask

    task automatic test_spurious_done();
        int bad = 0;
        do_reset();
        cnt_done = 1'b1;
        cnt_par  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack !== 4'b0000 || cnt_init !== 1'b0 || par_out !== 1'b0) bad++;
        end
        cnt_done = 1'b0;
        cnt_par  = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL spurious_done bad_cycles=%0d exp=0", bad); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        bit got = 1'b0;
        int bad = 0;
        do_reset();
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (cnt_init) got = 1'b1;
        end
        @(posedge clk); #1;
        req = '0;
        #2 rst = 1'b1;
        #1;
        total += 3;
        if (got !== 1'b1) $display("FAIL rstmid_init got=%b exp=1", got); else passed++;
        if (cnt_data !== 8'h00) $display("FAIL rstmid_async_data got=%h exp=00", cnt_data); else passed++;
        if (ack !== 4'b0000 || cnt_init !== 1'b0) $display("FAIL rstmid_async_ctl ack=%b init=%b exp=0000/0", ack, cnt_init); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_done = 1'b1;
        cnt_par  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack !== 4'b0000 || cnt_init !== 1'b0 || par_out !== 1'b0 || err !== 1'b0) bad++;
        end
        cnt_done = 1'b0;
        cnt_par  = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL rstmid_late_done bad_cycles=%0d exp=0", bad); else passed++;
    endtask

    task automatic test_watchdog();
        bit got = 1'b0;
        int edges = 0;
        bit seen = 1'b0;
        logic e = 1'b0, p = 1'b1;
        logic [3:0] a = '0;
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (cnt_init) got = 1'b1;
        end
        req = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            edges++;
            if (ack !== 4'b0000) begin
                seen = 1'b1; a = ack; e = err; p = par_out;
            end
        end
        total++;
        if (got !== 1'b1) $display("FAIL wd_init got=%b exp=1", got); else passed++;
`ifdef PAR_WATCHDOG_EN
        total += 4;
        if (edges !== TIMEOUT + 1) $display("FAIL wd_latency got=%0d exp=%0d", edges, TIMEOUT + 1); else passed++;
        if (a !== 4'b0010) $display("FAIL wd_ack got=%b exp=0010", a); else passed++;
        if (e !== 1'b1) $display("FAIL wd_err got=%b exp=1", e); else passed++;
        if (p !== 1'b0) $display("FAIL wd_par got=%b exp=0", p); else passed++;
`else
        total += 2;
        if (seen !== 1'b0) $display("FAIL wd_no_ack got=%b exp=0 ack=%b", seen, a); else passed++;
        if (err !== 1'b0) $display("FAIL wd_err_tied got=%b exp=0", err); else passed++;
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_spurious_done();
        test_reset_mid_wait();
        test_watchdog();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
